// File: rtl/ifu_prefetch_if.sv
// Prefetch queue port bundle: iram read port, redirect and decode handshake.
// master = prefetch queue, slave = iram/decode environment.
interface ifu_prefetch_if;
  logic [31:0] pc_n_o;
  logic        iram_rd_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        ifq_empty_o;

  modport master (
    output pc_n_o, iram_rd_o,
    output inst_o, inst_pc_o,
    output inst_valid_o, ifq_empty_o,
    input  pc_i, inst_i,
    input  jump_i, jump_addr_i,
    input  inst_ready_i
  );

  modport slave (
    input  pc_n_o, iram_rd_o,
    input  inst_o, inst_pc_o,
    input  inst_valid_o, ifq_empty_o,
    output pc_i, inst_i,
    output jump_i, jump_addr_i,
    output inst_ready_i
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch queue between iram read port and decode.
// IFQ_BYPASS_EN: empty-queue response goes straight to decode.
module ifu_prefetch #(
  parameter logic [31:0] RST_PC     = 32'h0800_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  ifu_prefetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          inflight;

  logic [31:0] mem_pc   [FIFO_DEPTH];
  logic [31:0] mem_inst [FIFO_DEPTH];

  logic [31:0] tgt;
  logic [CW:0] used;
  logic        issue;
  logic        head_vld;
  logic        resp;
  logic        byp;
  logic        push;
  logic        pop;

  always_comb begin
    tgt      = {bus.jump_addr_i[31:2], 2'b00};
    // Credit uses pre-pop count, so the queue can never overflow
    used     = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue    = !rst && (bus.jump_i || (used < DEPTH_L));
    head_vld = (count != '0);
    resp     = inflight && !bus.jump_i && !rst;
`ifdef IFQ_BYPASS_EN
    byp      = resp && !head_vld;
`else
    byp      = 1'b0;
`endif
    push     = resp && !(byp && bus.inst_ready_i);
    pop      = head_vld && bus.inst_ready_i && !bus.jump_i;

    bus.iram_rd_o    = issue;
    bus.pc_n_o       = rst ? RST_PC : (bus.jump_i ? tgt : fetch_pc);
    bus.ifq_empty_o  = !head_vld;
    bus.inst_valid_o = !rst && !bus.jump_i && (head_vld || byp);
    bus.inst_o       = '0;
    bus.inst_pc_o    = '0;
    if (head_vld) begin
      bus.inst_o    = mem_inst[rd_ptr];
      bus.inst_pc_o = mem_pc[rd_ptr];
    end else if (byp) begin
      bus.inst_o    = bus.inst_i;
      bus.inst_pc_o = bus.pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RST_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (bus.jump_i) begin
        fetch_pc <= tgt + 32'd4;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 32'd4;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= bus.pc_i;
      mem_inst[wr_ptr] <= bus.inst_i;
    end
  end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction prefetch queue directly downstream of the instruction RAM read port in the core fetch path.
- Generates next-fetch address and read enable toward iram, captures returned {pc, inst} pairs into a small FIFO, and presents them to decode with valid/ready.
- Handles redirect (jump/trap) by flushing queued and in-flight instructions and refetching from the new address.

Parameters:
- RST_PC, 32'h0800_0000, fetch address issued first after reset (ISP region).
- FIFO_DEPTH, 4, queue entries; power of 2, range 2..16.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- pc_n_o  output  32  fetch address to iram read port; bits [1:0] always 0.
- iram_rd_o  output  1  iram read enable; data returns exactly 1 cycle later.
- pc_i  input  32  address of returned instruction (iram registered pc).
- inst_i  input  32  returned instruction word.
- jump_i  input  1  redirect request, single-cycle pulse.
- jump_addr_i  input  32  redirect target.
- inst_o  output  32  instruction to decode.
- inst_pc_o  output  32  pc of inst_o.
- inst_valid_o  output  1  inst_o/inst_pc_o valid.
- inst_ready_i  input  1  decode accepts; transfer when valid & ready.
- ifq_empty_o  output  1  queue holds no entries.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- State on reset: fetch_pc=RST_PC, count=0, rd/wr pointers=0, inflight=0. Outputs: iram_rd_o=0, pc_n_o=RST_PC, inst_valid_o=0, ifq_empty_o=1, inst_o/inst_pc_o=0.
- Reset mid-operation: all queued and in-flight data discarded. Any response arriving in the first cycle after reset is ignored (inflight=0).
- Issue rule: iram_rd_o=1 when not in reset and (count + inflight) < FIFO_DEPTH.
  - The credit check uses the pre-pop count, so it is conservative and overflow is impossible.
  - On issue: pc_n_o=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap to 0), inflight<=1. Otherwise inflight<=0.
  - With the credit check satisfied, issue is back-to-back: one read per cycle.
- Response: when inflight=1, {pc_i, inst_i} are valid this cycle and are pushed to the FIFO unless jump_i=1.
- Pop: on inst_valid_o & inst_ready_i, advance rd pointer.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output: inst_valid_o = (count!=0). inst_o/inst_pc_o come from the head entry, combinationally from the registered array.
- Redirect (jump_i=1), highest priority below reset:
  - The current-cycle response is dropped, the FIFO is cleared (count<=0, pointers<=0), and no pop occurs.
  - Combinationally pc_n_o=jump_addr_i&~3 and iram_rd_o=1; then fetch_pc<=(jump_addr_i&~3)+4 and inflight<=1.
  - Target bits [1:0] are ignored.
  - inst_valid_o is forced to 0 in the jump cycle.
- Back-to-back jumps: each jump cancels the previous target's response; only the last target's stream survives.
- Latency (no bypass): jump/issue at cycle t -> response t+1 -> inst_valid_o at t+2.
- Full: count=FIFO_DEPTH with inflight=0 implies iram_rd_o=0. Fetch resumes the cycle after the first pop.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count=0, inflight=1 and jump_i=0, the response is driven straight to inst_o/inst_pc_o with inst_valid_o=1 in the same cycle. If inst_ready_i=1 the entry is not written; otherwise it is pushed normally. Issue-to-valid latency becomes 1 cycle.
- Not defined: all responses pass through the FIFO, giving 2-cycle latency. There is no combinational path from inst_i to inst_o.

Test Plan:
- Reset release, inst_ready_i=1 constantly -> pc_n_o sequence 0x08000000, 0x08000004, 0x08000008… issued every cycle. inst_pc_o matches 2 cycles later (1 with IFQ_BYPASS_EN); ifq_empty_o drops after first push.
- inst_ready_i=0 from reset -> exactly FIFO_DEPTH=4 reads issued, then iram_rd_o=0. Raise ready for 1 cycle -> one pop, one new read issued next cycle, count never exceeds 4.
- Stream running, jump_i with jump_addr_i=0x00000102 -> pc_n_o=0x00000100 same cycle, queue cleared, pending response dropped. Next inst_pc_o values are 0x100, 0x104.
- Jumps on two consecutive cycles to 0x200 then 0x300 -> no instruction from 0x200 ever valid; first delivered inst_pc_o=0x300.
- rst asserted while queue full and read in flight -> following cycle inst_valid_o=0, pc_n_o=RST_PC, stale response ignored.
- fetch_pc=0xFFFFFFFC, ready=1 -> next pc_n_o=0x00000000 (wrap), pcs delivered in order.
